// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, mid-bit sampling, optional even parity,
// held output word with parity/frame/overrun flags cleared by a read acknowledge.
module uart_rx #(
    parameter int unsigned BaudRate        = 9600,
    parameter int unsigned ParityBit       = 0,
    parameter int unsigned DataBitsSizeInt = 8,
    parameter int unsigned StopBitsSize    = 1,
    parameter int unsigned ClockFreqHz     = 10000000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rx_sig,
    input  logic                       read,
    output logic [DataBitsSizeInt-1:0] read_data,
    output logic                       rx_valid,
    output logic                       parity_err,
    output logic                       frame_err,
    output logic                       overrun_err
);

    localparam int unsigned SClkPeriod = ClockFreqHz / BaudRate;
    localparam int unsigned CntW       = $clog2(SClkPeriod) + 1;
    localparam int unsigned BitW       = $clog2(DataBitsSizeInt + 1);
    localparam int unsigned N          = DataBitsSizeInt;

    localparam logic [CntW-1:0] HalfLast = CntW'(SClkPeriod / 2 - 1);
    localparam logic [CntW-1:0] FullLast = CntW'(SClkPeriod - 1);
    localparam logic [BitW-1:0] LastBit  = BitW'(DataBitsSizeInt - 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [BitW-1:0] bit_cnt_q, bit_cnt_d;
    logic [N-1:0]    shift_q, shift_d;
    logic            par_err_q, par_err_d;
    logic            rx_meta_q, rx_s_q, rx_prev_q;
    logic            done;

    // Only the first stop bit is ever checked, so the stop-bit count has no effect here.
    logic unused_stop_cfg;
    assign unused_stop_cfg = (StopBitsSize != 0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_sig;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CntW'(1);
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_err_d = par_err_q;
        done      = 1'b0;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_s_q) begin
                    state_d   = StStart;
                    par_err_d = 1'b0;
                end
            end
            StStart: begin
                if (cnt_q == HalfLast) begin
                    cnt_d   = '0;
                    state_d = rx_s_q ? StIdle : StData;
                end
            end
            StData: begin
                if (cnt_q == FullLast) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[N-1:1]};
                    if (bit_cnt_q == LastBit) begin
                        bit_cnt_d = '0;
                        state_d   = (ParityBit != 0) ? StParity : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitW'(1);
                    end
                end
            end
            StParity: begin
                if (cnt_q == FullLast) begin
                    cnt_d     = '0;
                    par_err_d = (^shift_q) ^ rx_s_q;
                    state_d   = StStop;
                end
            end
            StStop: begin
                if (cnt_q == FullLast) begin
                    cnt_d   = '0;
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d   = StIdle;
                cnt_d     = '0;
                bit_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_err_q <= par_err_d;
        end
    end

    // A completing frame takes priority over a simultaneous read acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data   <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else if (done) begin
            read_data   <= shift_q;
            rx_valid    <= 1'b1;
            parity_err  <= (ParityBit != 0) && par_err_q;
            frame_err   <= ~rx_s_q;
            overrun_err <= rx_valid && !read;
        end else if (read && rx_valid) begin
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: two instances (no parity / even parity), directed frames plus
// random frames checked every cycle against a frame-level model of the held outputs.
module tb_uart_rx;

    localparam int P = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx [2];
    logic       rd [2];
    logic [7:0] rdata [2];
    logic       valid [2];
    logic       perr [2];
    logic       ferr [2];
    logic       ovr [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int         tc;
        logic [7:0] data;
        bit         perr;
        bit         ferr;
    } pend_t;

    pend_t      pq0 [$];
    pend_t      pq1 [$];
    bit         m_valid [2];
    bit         m_perr [2];
    bit         m_ferr [2];
    bit         m_ovr [2];
    logic [7:0] m_data [2];
    int         last_tc [2];

    always #5 clk = ~clk;

    uart_rx #(
        .BaudRate(10), .ParityBit(0), .DataBitsSizeInt(8), .StopBitsSize(0), .ClockFreqHz(160)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .rx_sig(rx[0]), .read(rd[0]), .read_data(rdata[0]),
        .rx_valid(valid[0]), .parity_err(perr[0]), .frame_err(ferr[0]), .overrun_err(ovr[0])
    );

    uart_rx #(
        .BaudRate(10), .ParityBit(1), .DataBitsSizeInt(8), .StopBitsSize(1), .ClockFreqHz(160)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .rx_sig(rx[1]), .read(rd[1]), .read_data(rdata[1]),
        .rx_valid(valid[1]), .parity_err(perr[1]), .frame_err(ferr[1]), .overrun_err(ovr[1])
    );

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    task automatic apply(input int i, input pend_t p);
        m_ovr[i]   = m_valid[i];
        m_valid[i] = 1'b1;
        m_data[i]  = p.data;
        m_perr[i]  = p.perr;
        m_ferr[i]  = p.ferr;
        last_tc[i] = p.tc;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 1'b0;
            m_perr[i]  = 1'b0;
            m_ferr[i]  = 1'b0;
            m_ovr[i]   = 1'b0;
            m_data[i]  = 8'h00;
            last_tc[i] = -1000;
        end
        pq0.delete();
        pq1.delete();
    endtask

    // Word is nominally complete at the middle of the first stop bit; a few cycles of
    // synchronizer/edge-detect latency around that point are left unchecked.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            for (int i = 0; i < 2; i++) begin
                bit near;
                near = 1'b0;
                if (i == 0) begin
                    while (pq0.size() > 0 && pq0[0].tc <= cyc) begin
                        apply(0, pq0[0]);
                        void'(pq0.pop_front());
                    end
                    if (pq0.size() > 0 && cyc >= pq0[0].tc - 2) near = 1'b1;
                end else begin
                    while (pq1.size() > 0 && pq1[0].tc <= cyc) begin
                        apply(1, pq1[0]);
                        void'(pq1.pop_front());
                    end
                    if (pq1.size() > 0 && cyc >= pq1[0].tc - 2) near = 1'b1;
                end
                if (cyc <= last_tc[i] + 8) near = 1'b1;
                if (!near) begin
                    check($sformatf("cmp_valid%0d", i), int'(valid[i]), int'(m_valid[i]));
                    check($sformatf("cmp_data%0d", i), int'(rdata[i]), int'(m_data[i]));
                    check($sformatf("cmp_perr%0d", i), int'(perr[i]), int'(m_perr[i]));
                    check($sformatf("cmp_ferr%0d", i), int'(ferr[i]), int'(m_ferr[i]));
                    check($sformatf("cmp_ovr%0d", i), int'(ovr[i]), int'(m_ovr[i]));
                end
            end
        end
    end

    // Called on a falling clock edge; drives one full frame, LSB first.
    task automatic send_frame(input int i, input logic [7:0] d, input bit bad_par,
                              input bit bad_stop);
        pend_t p;
        p.tc   = cyc + (1 + 8 + i) * P + P / 2;
        p.data = d;
        p.perr = (i == 1) && bad_par;
        p.ferr = bad_stop;
        if (i == 0) pq0.push_back(p);
        else        pq1.push_back(p);
        rx[i] = 1'b0;
        repeat (P) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rx[i] = d[k];
            repeat (P) @(negedge clk);
        end
        if (i == 1) begin
            rx[i] = (^d) ^ bad_par;
            repeat (P) @(negedge clk);
        end
        rx[i] = ~bad_stop;
        repeat (P) @(negedge clk);
        if (i == 1 || bad_stop) begin
            rx[i] = 1'b1;
            repeat (P) @(negedge clk);
        end
    endtask

    task automatic do_read(input int i);
        rd[i] = 1'b1;
        if (m_valid[i]) begin
            m_valid[i] = 1'b0;
            m_perr[i]  = 1'b0;
            m_ferr[i]  = 1'b0;
            m_ovr[i]   = 1'b0;
        end
        @(negedge clk);
        rd[i] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rx[0] = 1'b1;
        rx[1] = 1'b1;
        rd[0] = 1'b0;
        rd[1] = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_valid", int'(valid[0]), 0);
        check("reset_data", int'(rdata[0]), 0);
        check("reset_flags", int'({perr[1], ferr[1], ovr[1]}), 0);
        rst_n = 1'b1;
        idle(5);

        send_frame(0, 8'hA5, 1'b0, 1'b0);
        check("a5_data", int'(rdata[0]), 'hA5);
        check("a5_valid", int'(valid[0]), 1);
        check("a5_flags", int'({perr[0], ferr[0], ovr[0]}), 0);
        do_read(0);

        rx[0] = 1'b0;
        idle(4);
        rx[0] = 1'b1;
        idle(2 * P);
        check("glitch_valid", int'(valid[0]), 0);

        send_frame(0, 8'h3C, 1'b0, 1'b1);
        check("ferr_data", int'(rdata[0]), 'h3C);
        check("ferr_valid", int'(valid[0]), 1);
        check("ferr_flag", int'(ferr[0]), 1);
        do_read(0);
        idle(3);

        send_frame(1, 8'h07, 1'b1, 1'b0);
        check("par_bad", int'(perr[1]), 1);
        do_read(1);
        send_frame(1, 8'h07, 1'b0, 1'b0);
        check("par_good", int'(perr[1]), 0);
        check("par_data", int'(rdata[1]), 'h07);
        do_read(1);

        send_frame(0, 8'h11, 1'b0, 1'b0);
        send_frame(0, 8'h22, 1'b0, 1'b0);
        check("ovr_data", int'(rdata[0]), 'h22);
        check("ovr_flag", int'(ovr[0]), 1);
        do_read(0);
        check("ovr_clr_valid", int'(valid[0]), 0);
        check("ovr_clr_flag", int'(ovr[0]), 0);
        do_read(0);
        check("read_idle_valid", int'(valid[0]), 0);

        fork
            send_frame(0, 8'hFF, 1'b0, 1'b0);
            begin
                idle(3 * P);
                rst_n = 1'b0;
                model_reset();
                idle(3);
                rst_n = 1'b1;
            end
        join
        check("rst_abandon", int'(valid[0]), 0);
        send_frame(0, 8'h55, 1'b0, 1'b0);
        check("rst_data", int'(rdata[0]), 'h55);
        check("rst_valid", int'(valid[0]), 1);
        check("rst_flags", int'({perr[0], ferr[0], ovr[0]}), 0);
        do_read(0);
        idle(3);

        for (int n = 0; n < 40; n++) begin
            int         i;
            logic [7:0] d;
            i = int'($urandom_range(1, 0));
            d = 8'($urandom);
            send_frame(i, d, ($urandom_range(3, 0) == 0), ($urandom_range(3, 0) == 0));
            if ($urandom_range(1, 0) == 1) do_read(i);
            if ($urandom_range(3, 0) != 0) idle(int'($urandom_range(20, 1)));
        end
        idle(3 * P);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BaudRate, default 9600, serial bit rate in bits/s.
REQ-002 SHALL have parameter ParityBit, default 0, 1 = one even-parity bit follows the data bits, 0 = no parity bit.
REQ-003 SHALL have parameter DataBitsSizeInt, default 8, data bits per frame (5..9).
REQ-004 SHALL have parameter StopBitsSize, default 1, 0 = one stop bit, 1 = two stop bits; only the first stop bit is checked.
REQ-005 SHALL have parameter ClockFreqHz, default 10000000, clk frequency in Hz.
REQ-006 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port rx_sig, input, 1, asynchronous serial line, idle high.
REQ-009 SHALL have port read, input, 1, consumer acknowledge; a high cycle clears rx_valid and all error flags.
REQ-010 SHALL have port read_data, output, DataBitsSizeInt, last received data word, LSB = first bit on the line.
REQ-011 SHALL have port rx_valid, output, 1, level; read_data holds an unread word.
REQ-012 SHALL have port parity_err, output, 1, parity mismatch in the held word (always 0 when ParityBit=0).
REQ-013 SHALL have port frame_err, output, 1, first stop bit sampled low in the held word.
REQ-014 SHALL have port overrun_err, output, 1, a word completed while rx_valid=1 and read=0.

Function
REQ-015 SHALL define SClkPeriod = ClockFreqHz/BaudRate (integer division), with the clock counter at least $clog2(SClkPeriod)+1 bits wide.
REQ-016 SHALL pass rx_sig through a 2-flop synchronizer (reset value 1); all logic uses the synchronized value rx_s and its one-cycle-delayed copy.
REQ-017 SHALL implement the states IDLE, START, DATA, PARITY, STOP; any illegal encoding goes to IDLE.
REQ-018 IDLE: on a falling edge of rx_s (previous 1, current 0), go to START and clear the clock counter; a line held low never retriggers.
REQ-019 START: at counter == SClkPeriod/2-1, if rx_s=0 then clear the counter and go to DATA; if rx_s=1 (glitch) then return to IDLE with no output change.
REQ-020 DATA: at counter == SClkPeriod-1, sample rx_s into the shift register LSB-first, increment the bit counter, and clear the clock counter.
REQ-021 After the sample numbered DataBitsSizeInt-1 (0-based), the next state is PARITY if ParityBit=1, else STOP; the bit counter resets to 0.
REQ-022 PARITY: at counter == SClkPeriod-1, sample rx_s; the parity error is (XOR of data bits XOR sample) != 0; then go to STOP.
REQ-023 STOP: at counter == SClkPeriod-1, sample rx_s and go to IDLE; on the next cycle read_data = shift register, rx_valid=1, frame_err = ~sample, and parity_err is updated.
REQ-024 Word delivery is the same whether or not errors are present; errors never suppress rx_valid.
REQ-025 Completion with rx_valid=1 and read=0 SHALL overwrite read_data and set overrun_err=1.
REQ-026 Completion in the same cycle as read=1 SHALL load the new word with rx_valid=1 and overrun_err=0; the new completion wins over the clear.
REQ-027 read=1 while rx_valid=0 SHALL have no effect.
REQ-028 The falling edge at the end of the stop bit SHALL be accepted in IDLE, so back-to-back frames are received with no gap.

Reset
REQ-029 On rst_n=0, asynchronously: state=IDLE, counters=0, shift register=0, synchronizer flops=1, read_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun_err=0.
REQ-030 Reset mid-frame SHALL abandon the frame; after release, reception resumes only on a new falling edge.

Verification (ClockFreqHz=160, BaudRate=10, so SClkPeriod=16; DataBitsSizeInt=8)
REQ-031 Frame 0x A5 (start, bits 1,0,1,0,0,1,0,1, stop) with ParityBit=0 -> rx_valid rises about 152 cycles after the start edge; read_data=0xA5 and all error flags are 0.
REQ-032 rx_sig low for 4 cycles, then high -> no state leaves IDLE after START, and rx_valid stays 0.
REQ-033 Frame 0x3C with the stop bit driven low -> read_data=0x3C, rx_valid=1, frame_err=1.
REQ-034 ParityBit=1, frame 0x07 with parity bit 0 (correct value is 1) -> parity_err=1; the same frame with parity bit 1 -> parity_err=0.
REQ-035 Two back-to-back frames 0x11 then 0x22 with no read -> read_data=0x22 and overrun_err=1; then read=1 -> rx_valid=0 and overrun_err=0.
REQ-036 rst_n pulsed low during the data bits of frame 0xFF, then frame 0x55 sent -> only 0x55 is delivered, with no error flags.
